// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its frame timer.
package uart_pkg;

  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  // One start bit, eight data bits and one stop bit, each lasting one baud period.
  function automatic int frame_cycles(input int clk_freq, input int uart_bps);
    return FRAME_BITS * (clk_freq / uart_bps);
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Counts the clock cycles of one serial frame; done flags the final cycle of the frame.
module uart_frame_timer
  import uart_pkg::*;
#(
  parameter int UART_BPS = 'd9600,
  parameter int CLK_FREQ = 'd50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic start,
  input  logic clear,
  output logic done
);

  localparam int FRAME_CYCLES = frame_cycles(CLK_FREQ, UART_BPS);
  localparam int CNT_W = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturate at the last frame cycle so an idle timer never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (start && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding two byte requesters into one UART transmitter,
// holding off further grants until the current serial frame has gone out.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int UART_BPS = 'd9600,
  parameter int CLK_FREQ = 'd50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       po_id,
  output logic       busy
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic [7:0] po_data_q;
  logic [7:0] po_data_d;
  logic       po_id_q;
  logic       po_id_d;
  logic       last_grant_q;
  logic       last_grant_d;
  logic       grant_vld;
  logic       grant_id;
  logic       timer_start;
  logic       timer_clear;
  logic       frame_done;

  // Arbitration: contention goes to whoever was not served last.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if ((state_q == IDLE) && !sys_rst) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld & ~grant_id;
  assign req1_ready = grant_vld & grant_id;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_vld) state_d = SEND;
      SEND:    state_d = WAIT;
      WAIT:    if (frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    po_flag     = (state_q == SEND);
    busy        = (state_q != IDLE);
    timer_clear = (state_q == SEND);
    timer_start = (state_q == WAIT);
  end

  always_comb begin
    po_data_d    = po_data_q;
    po_id_d      = po_id_q;
    last_grant_d = last_grant_q;
    if (grant_vld) begin
      po_data_d    = grant_id ? req1_data : req0_data;
      po_id_d      = grant_id;
      last_grant_d = grant_id;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      po_data_q    <= 8'h00;
      po_id_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      po_data_q    <= po_data_d;
      po_id_q      <= po_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign po_data = po_data_q;
  assign po_id   = po_id_q;

  uart_frame_timer #(
    .UART_BPS(UART_BPS),
    .CLK_FREQ(CLK_FREQ)
  ) u_frame_timer (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .start  (timer_start),
    .clear  (timer_clear),
    .done   (frame_done)
  );

endmodule
